imc_array_ctrl: RTL and testbench
=================================

# imc_array_ctrl

Sequencer between the CPU data path and the virtual memristor crossbar. It consumes the data path's bit-select, control, word and gate-select outputs and runs the multi-cycle memristor operation they request: write, OR-read, AND, XOR or INV. It returns the result on `data` with busy/done status, and can optionally write the result back into a destination row.

## Interface
- `ROWS`, 32: crossbar rows, each 32 bits wide.
- `ADDR_W`, 5: row address width, equal to log2(ROWS).
- `EVAL_CYCLES`, 2: memristor settle time in cycles, applied to both evaluate and programming phases; minimum 1.

- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `bit_data_sel_1` in 32: row A address; bits [ADDR_W-1:0] used, upper bits ignored.
- `bit_data_sel_2` in 32: row B address; same rule.
- `control` in 32: bit 0 start; bit 1 write; bit 2 writeback request; [8+:ADDR_W] destination row; all other bits ignored.
- `word` in 32: write data.
- `read_or_gate`, `and_gate`, `xor_gate`, `inv_gate` in 1 each: gate select.
- `data` out 32: result register.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: set with `done` when the command was illegal.

## Operation
- States: IDLE, SETUP, EVAL, SENSE, WB, PROG, DONE.
- Accept: IDLE and `control[0]`=1. Latch addresses, `word`, flags and gates, then go to SETUP.
- Write (`control[1]`=1, no gate asserted): SETUP → PROG for EVAL_CYCLES cycles → DONE. Row[A] ← `word` on the last PROG cycle. `data` is unchanged.
- Gate op (`control[1]`=0, exactly one gate asserted): SETUP → EVAL for EVAL_CYCLES cycles → SENSE.
  - In SENSE, `data` ← result: OR = A|B (read when A==B), AND = A&B, XOR = A^B, INV = ~A (B ignored).
  - Then WB if writeback is taken (see Configuration), otherwise DONE.
- Illegal command: zero or more than one gate with write=0, or any gate with write=1. Goes SETUP → DONE with `err`=1. The array and `data` are untouched.
- `err` holds its value until the next accept; `done` is high only in DONE.
- DONE → IDLE unconditionally. Start is level-sensitive, so a start held high re-issues the command.
- Start while not in IDLE is ignored; there is no queue.
- Reset clears the FSM only. Array contents persist, modelling non-volatile storage.

## Timing
- Reset values: state IDLE, `data`=0, `busy`=0, `done`=0, `err`=0. The sequence counter is cleared.
- Reset asserted mid-operation aborts it with no array update. If reset lands on the final PROG/WB cycle, the write is suppressed.
- Latency, counted from the accept edge to `done`:
  - Gate op: EVAL_CYCLES+3 cycles.
  - Gate op with writeback: 2·EVAL_CYCLES+3 cycles.
  - Write: EVAL_CYCLES+2 cycles.
  - Illegal command: 2 cycles.
- `data` is valid from the DONE cycle until the next SENSE.
- Array reads are combinational on the latched addresses and are sampled only in SENSE.
- Writeback or programming to a row that is also an operand affects only later commands.
- A, B and destination may all be equal.

## Configuration
- `IMC_WRITEBACK_EN` defined: when `control[2]`=1 on a legal gate op, WB lasts EVAL_CYCLES cycles and row[dest] ← result on the last WB cycle.
- `IMC_WRITEBACK_EN` undefined: no WB state exists and `control[2]` is ignored. The array is written only by write commands.

## Structure
- Package `imc_pkg`: state enum, control bit positions (START, WRITE, WB_REQ, DEST_LSB), and gate-select one-hot constants.
- Sub-module `memristor_row_array`: ROWS×32 storage with two combinational read ports and one synchronous write port. It has no reset.
- The FSM, evaluation counter and result datapath sit in `imc_array_ctrl`.

## Test plan
All scenarios use ROWS=32 and EVAL_CYCLES=2.

- Setup and OR: write row3=0xF0F0_00FF and row5=0x0FF0_FF0F; each write gives `done` 4 cycles after accept. An OR-read of rows 3,3 → `data`=0xF0F0_00FF, `done` 5 cycles after accept.
- Gate ops on rows 3,5:
  - AND → 0x00F0_000F.
  - XOR → 0xFF00_FFF0.
  - OR → 0xFFF0_FFFF.
  - INV row3 → 0x0F0F_FF00.
  - `err`=0 throughout.
- Writeback (`IMC_WRITEBACK_EN` defined): XOR rows 3,5 with dest 7 and `control[2]`=1 → `done` 7 cycles after accept. An OR-read of row7 then returns 0xFF00_FFF0. With the macro undefined, row7 is unchanged and `done` comes after 5 cycles.
- Illegal commands: AND and XOR asserted together, or write with INV → `done` and `err` after 2 cycles. `data` and the array are unchanged.
- Busy and start handling: start pulsed during EVAL is ignored. Start held high issues back-to-back commands, each separated by one IDLE cycle.
- Reset: `rst` asserted on the last PROG cycle of a write of 0xDEAD_BEEF to row3 → all outputs 0 next cycle. A later read of row3 returns 0xF0F0_00FF.

Source files
------------

// File: rtl/imc_pkg.sv
// imc_pkg -- shared types and constants for the memristor crossbar sequencer.
//
// Contents:
//   imc_state_e    sequencer state encoding
//   CTRL_*         bit positions inside the 32-bit control word
//   GATE_*         one-hot gate-select codes, packed as {inv, xor, and, or}
//   gate_onehot()  true when exactly one gate-select bit is set
package imc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_EVAL  = 3'd2,
      ST_SENSE = 3'd3,
      ST_WB    = 3'd4,
      ST_PROG  = 3'd5,
      ST_DONE  = 3'd6
   } imc_state_e;

   localparam int CTRL_START    = 0;
   localparam int CTRL_WRITE    = 1;
   localparam int CTRL_WB_REQ   = 2;
   localparam int CTRL_DEST_LSB = 8;

   localparam logic [3:0] GATE_OR  = 4'b0001;
   localparam logic [3:0] GATE_AND = 4'b0010;
   localparam logic [3:0] GATE_XOR = 4'b0100;
   localparam logic [3:0] GATE_INV = 4'b1000;

   function automatic logic gate_onehot(input logic [3:0] g);
      return (g != 4'b0000) && ((g & (g - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/imc_array_ctrl_if.sv
// imc_array_ctrl_if -- bundle between the CPU data path and the crossbar
// sequencer.
//
// Signals:
//   bit_data_sel_1/2  row A / row B address (low bits used)
//   control           start, write, writeback request, destination row
//   word              write data
//   read_or_gate, and_gate, xor_gate, inv_gate   gate select
//   data, busy, done, err                        sequencer result/status
//
// Modports:
//   master  data path side (drives the command)
//   slave   sequencer side (drives the result/status)
interface imc_array_ctrl_if;

   logic [31:0] bit_data_sel_1;
   logic [31:0] bit_data_sel_2;
   logic [31:0] control;
   logic [31:0] word;
   logic        read_or_gate;
   logic        and_gate;
   logic        xor_gate;
   logic        inv_gate;
   logic [31:0] data;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      output bit_data_sel_1, bit_data_sel_2, control, word,
             read_or_gate, and_gate, xor_gate, inv_gate,
      input  data, busy, done, err
   );

   modport slave (
      input  bit_data_sel_1, bit_data_sel_2, control, word,
             read_or_gate, and_gate, xor_gate, inv_gate,
      output data, busy, done, err
   );

endinterface

// File: rtl/memristor_row_array.sv
// memristor_row_array -- ROWS x 32-bit storage standing in for the crossbar.
// Contents are deliberately not reset: they model non-volatile cells.
//
// Ports:
//   clk      rising-edge clock
//   raddr_a  read port A address, rdata_a combinational
//   raddr_b  read port B address, rdata_b combinational
//   we       write enable, written on the rising edge
//   waddr    write address
//   wdata    write data
module memristor_row_array #(
   parameter int ROWS   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [31:0]       rdata_a,
   output logic [31:0]       rdata_b,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata
);

   logic [31:0] mem [ROWS];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/imc_array_ctrl.sv
// imc_array_ctrl -- sequences write / OR / AND / XOR / INV operations on the
// memristor row array and returns the result with busy/done/err status.
//
// Build option: define IMC_WRITEBACK_EN to enable the WB state, which writes
// a gate result back into the destination row when control[2] is set.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset (clears the FSM, not the array)
//   bus  imc_array_ctrl_if.slave: command in, data/busy/done/err out
//
// state | meaning
// IDLE  | waiting for start
// SETUP | command latched, legality decoded
// EVAL  | gate evaluation settling (EVAL_CYCLES)
// SENSE | result captured into data
// WB    | result programmed into destination row (EVAL_CYCLES)
// PROG  | word programmed into row A (EVAL_CYCLES)
// DONE  | one-cycle completion, err valid
module imc_array_ctrl
   import imc_pkg::*;
#(
   parameter int ROWS        = 32,
   parameter int ADDR_W      = 5,
   parameter int EVAL_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   imc_array_ctrl_if.slave bus
);

   localparam int               CNT_W    = (EVAL_CYCLES > 1) ? $clog2(EVAL_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EVAL_CYCLES - 1);

   imc_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              cnt_tc;
   logic [ADDR_W-1:0] addr_a_q, addr_b_q;
   logic [31:0]       word_q;
   logic              write_q;
   logic [3:0]        gates_q;
   logic [31:0]       data_q;
   logic              err_q;
   logic [31:0]       rd_a, rd_b, result;
   logic              accept, legal_write, legal_gate;
   logic              busy, done;
   logic              arr_we;
   logic [ADDR_W-1:0] arr_waddr;
   logic [31:0]       arr_wdata;
`ifdef IMC_WRITEBACK_EN
   logic              wb_req_q;
   logic [ADDR_W-1:0] dest_q;
`endif

   // Address bits above ADDR_W and unassigned control bits are don't-care.
   logic unused_bits;
`ifdef IMC_WRITEBACK_EN
   assign unused_bits = ^{bus.bit_data_sel_1[31:ADDR_W], bus.bit_data_sel_2[31:ADDR_W],
                          bus.control[31:CTRL_DEST_LSB+ADDR_W],
                          bus.control[CTRL_DEST_LSB-1:CTRL_WB_REQ+1]};
`else
   assign unused_bits = ^{bus.bit_data_sel_1[31:ADDR_W], bus.bit_data_sel_2[31:ADDR_W],
                          bus.control[31:CTRL_WB_REQ]};
`endif

   assign accept      = (state_q == ST_IDLE) && bus.control[CTRL_START];
   assign cnt_tc      = (cnt_q == '0);
   assign legal_write = write_q && (gates_q == 4'b0000);
   assign legal_gate  = !write_q && gate_onehot(gates_q);

   memristor_row_array #(
      .ROWS   (ROWS),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .raddr_a (addr_a_q),
      .raddr_b (addr_b_q),
      .rdata_a (rd_a),
      .rdata_b (rd_b),
      .we      (arr_we),
      .waddr   (arr_waddr),
      .wdata   (arr_wdata)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (accept) state_d = ST_SETUP;
         ST_SETUP: begin
            if (legal_write)     state_d = ST_PROG;
            else if (legal_gate) state_d = ST_EVAL;
            else                 state_d = ST_DONE;
         end
         ST_EVAL:  if (cnt_tc) state_d = ST_SENSE;
`ifdef IMC_WRITEBACK_EN
         ST_SENSE: state_d = wb_req_q ? ST_WB : ST_DONE;
         ST_WB:    if (cnt_tc) state_d = ST_DONE;
`else
         ST_SENSE: state_d = ST_DONE;
`endif
         ST_PROG:  if (cnt_tc) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Array writes are gated by rst so a reset on the final PROG/WB cycle
   // leaves the row untouched.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      done      = (state_q == ST_DONE);
      arr_we    = 1'b0;
      arr_waddr = addr_a_q;
      arr_wdata = word_q;
      if ((state_q == ST_PROG) && cnt_tc && !rst) arr_we = 1'b1;
`ifdef IMC_WRITEBACK_EN
      if ((state_q == ST_WB) && cnt_tc && !rst) begin
         arr_we    = 1'b1;
         arr_waddr = dest_q;
         arr_wdata = data_q;
      end
`endif
   end

   // Down-counter loaded on entry to each timed phase (EVAL after SETUP,
   // PROG after SETUP, WB after SENSE); terminal count marks the last cycle.
   always_ff @(posedge clk) begin
      if (rst)                                             cnt_q <= '0;
      else if ((state_q == ST_SETUP) || (state_q == ST_SENSE)) cnt_q <= CNT_LOAD;
      else if (!cnt_tc)                                    cnt_q <= cnt_q - 1'b1;
   end

   always_comb begin
      result = '0;
      case (gates_q)
         GATE_OR:  result = rd_a | rd_b;
         GATE_AND: result = rd_a & rd_b;
         GATE_XOR: result = rd_a ^ rd_b;
         GATE_INV: result = ~rd_a;
         default:  result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_a_q <= '0;
         addr_b_q <= '0;
         word_q   <= '0;
         write_q  <= 1'b0;
         gates_q  <= 4'b0000;
         data_q   <= '0;
         err_q    <= 1'b0;
`ifdef IMC_WRITEBACK_EN
         wb_req_q <= 1'b0;
         dest_q   <= '0;
`endif
      end else begin
         if (accept) begin
            addr_a_q <= bus.bit_data_sel_1[ADDR_W-1:0];
            addr_b_q <= bus.bit_data_sel_2[ADDR_W-1:0];
            word_q   <= bus.word;
            write_q  <= bus.control[CTRL_WRITE];
            gates_q  <= {bus.inv_gate, bus.xor_gate, bus.and_gate, bus.read_or_gate};
            err_q    <= 1'b0;
`ifdef IMC_WRITEBACK_EN
            wb_req_q <= bus.control[CTRL_WB_REQ];
            dest_q   <= bus.control[CTRL_DEST_LSB +: ADDR_W];
`endif
         end
         if ((state_q == ST_SETUP) && !legal_write && !legal_gate) err_q <= 1'b1;
         if (state_q == ST_SENSE) data_q <= result;
      end
   end

   assign bus.data = data_q;
   assign bus.busy = busy;
   assign bus.done = done;
   assign bus.err  = err_q;

endmodule

// File: tb/tb_imc_array_ctrl.sv
// tb_imc_array_ctrl -- scoreboard bench for imc_array_ctrl (ROWS=32,
// EVAL_CYCLES=2). Latency n means done is seen after the n-th rising edge,
// counting the edge that accepts the command as edge 1.
module tb_imc_array_ctrl;
   import imc_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imc_array_ctrl_if bus ();

   imc_array_ctrl #(
      .ROWS        (32),
      .ADDR_W      (5),
      .EVAL_CYCLES (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
   } exp_t;

   exp_t        sb_q[$];
   int          checks    = 0;
   int          failures  = 0;
   logic [31:0] last_data = 32'h0;

   task automatic bus_clear();
      bus.bit_data_sel_1 = '0;
      bus.bit_data_sel_2 = '0;
      bus.control        = '0;
      bus.word           = '0;
      bus.read_or_gate   = 1'b0;
      bus.and_gate       = 1'b0;
      bus.xor_gate       = 1'b0;
      bus.inv_gate       = 1'b0;
   endtask

   // Drive one command with random junk in the ignored bits.
   task automatic drive_cmd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dest,
                            input logic wr, input logic wbreq, input logic [31:0] w,
                            input logic [3:0] g);
      logic [31:0] s1, s2, ctl;
      s1 = $urandom(); s1[4:0] = a;
      s2 = $urandom(); s2[4:0] = b;
      ctl = $urandom() & 32'hFFFF_E0F8;
      ctl[0] = 1'b1; ctl[1] = wr; ctl[2] = wbreq; ctl[12:8] = dest;
      bus.bit_data_sel_1 = s1;
      bus.bit_data_sel_2 = s2;
      bus.control        = ctl;
      bus.word           = w;
      bus.read_or_gate   = g[0];
      bus.and_gate       = g[1];
      bus.xor_gate       = g[2];
      bus.inv_gate       = g[3];
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (bus.busy !== 1'b0 && n < 50) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic run_cmd(input logic [4:0] a, input logic [4:0] b, input logic [4:0] dest,
                          input logic wr, input logic wbreq, input logic [31:0] w,
                          input logic [3:0] g, output logic [31:0] d, output logic e,
                          output int lat);
      wait_idle();
      drive_cmd(a, b, dest, wr, wbreq, w, g);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 1) bus.control[0] = 1'b0;
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      d = bus.data;
      e = bus.err;
      bus_clear();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_clear();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", bus.err); end
      checks++; if (bus.data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.data); end
      rst = 1'b0;
   endtask

   task automatic test_setup_or();
      logic [4:0]  rows [3] = '{5'd3, 5'd5, 5'd7};
      logic [31:0] vals [3] = '{32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h1234_5678};
      logic [31:0] d; logic e; int lat; exp_t x;
      for (int i = 0; i < 3; i++) begin
         sb_q.push_back('{data: last_data, err: 1'b0, lat: 4});
         run_cmd(rows[i], 5'd0, 5'd0, 1'b1, 1'b0, vals[i], 4'b0000, d, e, lat);
         x = sb_q.pop_front();
         checks++; if (lat !== x.lat) begin failures++; $display("FAIL write_lat row=%0d got=%0d exp=%0d", rows[i], lat, x.lat); end
         checks++; if (e !== x.err) begin failures++; $display("FAIL write_err row=%0d got=%b exp=%b", rows[i], e, x.err); end
         checks++; if (d !== x.data) begin failures++; $display("FAIL write_data row=%0d got=%h exp=%h", rows[i], d, x.data); end
      end
      sb_q.push_back('{data: 32'hF0F0_00FF, err: 1'b0, lat: 5});
      run_cmd(5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      last_data = x.data;
      checks++; if (d !== x.data) begin failures++; $display("FAIL read3_data got=%h exp=%h", d, x.data); end
      checks++; if (lat !== x.lat) begin failures++; $display("FAIL read3_lat got=%0d exp=%0d", lat, x.lat); end
   endtask

   task automatic test_gate_ops();
      logic [3:0]  gt [4] = '{GATE_AND, GATE_XOR, GATE_OR, GATE_INV};
      logic [31:0] ex [4] = '{32'h00F0_000F, 32'hFF00_FFF0, 32'hFFF0_FFFF, 32'h0F0F_FF00};
      logic [31:0] d; logic e; int lat; exp_t x;
      for (int i = 0; i < 4; i++) begin
         sb_q.push_back('{data: ex[i], err: 1'b0, lat: 5});
         run_cmd(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, gt[i], d, e, lat);
         x = sb_q.pop_front();
         last_data = x.data;
         checks++; if (d !== x.data) begin failures++; $display("FAIL gate_data g=%b got=%h exp=%h", gt[i], d, x.data); end
         checks++; if (e !== x.err) begin failures++; $display("FAIL gate_err g=%b got=%b exp=%b", gt[i], e, x.err); end
         checks++; if (lat !== x.lat) begin failures++; $display("FAIL gate_lat g=%b got=%0d exp=%0d", gt[i], lat, x.lat); end
      end
   endtask

   task automatic test_writeback();
      logic [31:0] d; logic e; int lat; exp_t x;
      logic [31:0] row7_exp;
`ifdef IMC_WRITEBACK_EN
      sb_q.push_back('{data: 32'hFF00_FFF0, err: 1'b0, lat: 7});
      row7_exp = 32'hFF00_FFF0;
`else
      sb_q.push_back('{data: 32'hFF00_FFF0, err: 1'b0, lat: 5});
      row7_exp = 32'h1234_5678;
`endif
      run_cmd(5'd3, 5'd5, 5'd7, 1'b0, 1'b1, 32'h0, GATE_XOR, d, e, lat);
      x = sb_q.pop_front();
      checks++; if (lat !== x.lat) begin failures++; $display("FAIL wb_lat got=%0d exp=%0d", lat, x.lat); end
      checks++; if (d !== x.data) begin failures++; $display("FAIL wb_data got=%h exp=%h", d, x.data); end
      sb_q.push_back('{data: row7_exp, err: 1'b0, lat: 5});
      run_cmd(5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      last_data = x.data;
      checks++; if (d !== x.data) begin failures++; $display("FAIL wb_row7 got=%h exp=%h", d, x.data); end
   endtask

   task automatic test_illegal();
      logic [3:0]  gt [2] = '{GATE_AND | GATE_XOR, GATE_INV};
      logic        wr [2] = '{1'b0, 1'b1};
      logic [31:0] d; logic e; int lat; exp_t x;
      for (int i = 0; i < 2; i++) begin
         sb_q.push_back('{data: last_data, err: 1'b1, lat: 2});
         run_cmd(5'd3, 5'd5, 5'd3, wr[i], 1'b1, 32'hDEAD_0000, gt[i], d, e, lat);
         x = sb_q.pop_front();
         checks++; if (lat !== x.lat) begin failures++; $display("FAIL illegal_lat i=%0d got=%0d exp=%0d", i, lat, x.lat); end
         checks++; if (e !== x.err) begin failures++; $display("FAIL illegal_err i=%0d got=%b exp=%b", i, e, x.err); end
         checks++; if (d !== x.data) begin failures++; $display("FAIL illegal_data i=%0d got=%h exp=%h", i, d, x.data); end
         @(negedge clk);
         checks++; if (bus.err !== 1'b1) begin failures++; $display("FAIL illegal_err_hold i=%0d got=%b exp=1", i, bus.err); end
      end
      sb_q.push_back('{data: 32'hF0F0_00FF, err: 1'b0, lat: 5});
      run_cmd(5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      checks++; if (d !== x.data) begin failures++; $display("FAIL illegal_row3 got=%h exp=%h", d, x.data); end
      checks++; if (e !== x.err) begin failures++; $display("FAIL illegal_err_clear got=%b exp=%b", e, x.err); end
      sb_q.push_back('{data: 32'h0FF0_FF0F, err: 1'b0, lat: 5});
      run_cmd(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      last_data = x.data;
      checks++; if (d !== x.data) begin failures++; $display("FAIL illegal_row5 got=%h exp=%h", d, x.data); end
   endtask

   task automatic test_busy_start();
      logic [31:0] d; logic e; int lat; exp_t x;
      sb_q.push_back('{data: 32'h00F0_000F, err: 1'b0, lat: 5});
      wait_idle();
      drive_cmd(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, GATE_AND);
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (n == 1) bus.control[0] = 1'b0;
         if (n == 2) drive_cmd(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 32'h0, 4'b0000);
         if (n == 3) bus_clear();
         if (bus.done === 1'b1) begin
            lat = n;
            break;
         end
      end
      d = bus.data;
      bus_clear();
      x = sb_q.pop_front();
      last_data = x.data;
      checks++; if (lat !== x.lat) begin failures++; $display("FAIL busy_lat got=%0d exp=%0d", lat, x.lat); end
      checks++; if (d !== x.data) begin failures++; $display("FAIL busy_data got=%h exp=%h", d, x.data); end
      repeat (2) begin
         @(posedge clk); #1;
         checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL busy_no_reissue got=%b exp=0", bus.busy); end
      end
      sb_q.push_back('{data: 32'h0FF0_FF0F, err: 1'b0, lat: 5});
      run_cmd(5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      last_data = x.data;
      checks++; if (d !== x.data) begin failures++; $display("FAIL busy_row5 got=%h exp=%h", d, x.data); end
   endtask

   task automatic test_back_to_back();
      int done_q[$];
      int exp_n;
      done_q.push_back(5); done_q.push_back(11); done_q.push_back(17);
      wait_idle();
      drive_cmd(5'd3, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR);
      for (int n = 1; n <= 22; n++) begin
         @(posedge clk); #1;
         if (n == 6) begin
            checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap got=%b exp=0", bus.busy); end
         end
         if (n == 7) begin
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_reissue got=%b exp=1", bus.busy); end
         end
         if (bus.done === 1'b1) begin
            if (done_q.size() == 0) begin
               checks++; failures++;
               $display("FAIL b2b_extra_done at=%0d exp=none", n);
            end else begin
               exp_n = done_q.pop_front();
               checks++; if (n !== exp_n) begin failures++; $display("FAIL b2b_done_pos got=%0d exp=%0d", n, exp_n); end
               checks++; if (bus.data !== 32'hFFF0_FFFF) begin failures++; $display("FAIL b2b_data got=%h exp=fff0ffff", bus.data); end
               if (done_q.size() == 0) bus.control[0] = 1'b0;
            end
         end
      end
      checks++; if (done_q.size() !== 0) begin failures++; $display("FAIL b2b_missing_done got=%0d exp=0", done_q.size()); end
      last_data = 32'hFFF0_FFFF;
      bus_clear();
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] d; logic e; int lat; exp_t x;
      wait_idle();
      drive_cmd(5'd3, 5'd0, 5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 4'b0000);
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk); #1;
         if (n == 1) bus.control[0] = 1'b0;
         if (n == 3) begin
            checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL rstw_in_prog got=%b exp=1", bus.busy); end
            rst = 1'b1;
         end
      end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstw_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstw_done got=%b exp=0", bus.done); end
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL rstw_err got=%b exp=0", bus.err); end
      checks++; if (bus.data !== 32'h0) begin failures++; $display("FAIL rstw_data got=%h exp=0", bus.data); end
      rst = 1'b0;
      bus_clear();
      sb_q.push_back('{data: 32'hF0F0_00FF, err: 1'b0, lat: 5});
      run_cmd(5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 32'h0, GATE_OR, d, e, lat);
      x = sb_q.pop_front();
      checks++; if (d !== x.data) begin failures++; $display("FAIL rstw_row3 got=%h exp=%h", d, x.data); end
      checks++; if (lat !== x.lat) begin failures++; $display("FAIL rstw_lat got=%0d exp=%0d", lat, x.lat); end
   endtask

   initial begin
      bus_clear();
      test_reset();
      test_setup_or();
      test_gate_ops();
      test_writeback();
      test_illegal();
      test_busy_start();
      test_back_to_back();
      test_reset_mid_write();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1);
   end

endmodule
